shift_normalizer_seq: RTL and testbench

- Iterative normalizer: the counterpart of the 8-bit left/right shifter stage.
- The shifter takes an operand and a shift amount. This block takes an operand and computes the shift amount that normalizes it:
  - left mode: MSB set.
  - right mode: LSB set.
- Shifts one bit per clock and returns both the normalized value and the count.
- The count is 3 bits, the same width the shifter stage's amount input uses, so it drives that input directly.
- Uses a start/ready/done_tick handshake and sits beside the shifter stage in the datapath.

---
 rtl/shift_normalizer_seq_pkg.sv | 10 +
 rtl/shift_normalizer_seq.sv | 66 ++++++
 tb/tb_shift_normalizer_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shift_normalizer_seq_pkg.sv
// shift_normalizer_seq_pkg: shared widths and FSM encoding for the normalizer and shifter stage
package shift_normalizer_seq_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_AMT_W = 3;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OP   = 2'b01,
    S_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/shift_normalizer_seq.sv
// shift_normalizer_seq: one-bit-per-clock normalizer (clk, reset, start/dir/din in; ready, done_tick, dout, amt, zero out)
module shift_normalizer_seq
  import shift_normalizer_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              done_tick,
  output logic [DATA_W-1:0] dout,
  output logic [AMT_W-1:0]  amt,
  output logic              zero
);
  state_t state, state_n;
  logic [DATA_W-1:0] d_reg, d_n;
  logic [AMT_W-1:0] n_reg, n_n;
  logic dir_reg, dir_n, zero_reg, zero_n, stop;
  assign stop = (dir_reg ? d_reg[0] : d_reg[DATA_W-1]) || d_reg == '0;
  assign dout = d_reg;
  assign amt = n_reg;
  assign zero = zero_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      d_reg <= '0;
      n_reg <= '0;
      dir_reg <= 1'b0;
      zero_reg <= 1'b0;
    end else begin
      state <= state_n;
      d_reg <= d_n;
      n_reg <= n_n;
      dir_reg <= dir_n;
      zero_reg <= zero_n;
    end
  end
  always_comb begin
    state_n = state;
    d_n = d_reg;
    n_n = n_reg;
    dir_n = dir_reg;
    zero_n = zero_reg;
    ready = state == S_IDLE;
    done_tick = state == S_DONE;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_OP;
        d_n = din;
        n_n = '0;
        dir_n = dir;
        zero_n = din == '0;
      end
      S_OP: if (stop) state_n = S_DONE;
      else begin
        d_n = dir_reg ? d_reg >> 1 : d_reg << 1;
        n_n = n_reg + AMT_W'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_shift_normalizer_seq.sv
// tb_shift_normalizer_seq: scoreboard bench for shift_normalizer_seq
module tb_shift_normalizer_seq;
  typedef struct {
    logic [7:0] din;
    logic dir;
    logic [7:0] dout;
    logic [2:0] amt;
    logic zero;
    int cap;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, dir = 1'b0;
  logic [7:0] din = '0;
  logic ready, done_tick, zero;
  logic [7:0] dout;
  logic [2:0] amt;
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0, low_run = 0;
  exp_t q[$];
  shift_normalizer_seq dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .din(din),
    .ready(ready), .done_tick(done_tick), .dout(dout), .amt(amt), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [7:0] d, input logic r);
    exp_t e;
    e.din = d;
    e.dir = r;
    e.dout = d;
    e.amt = '0;
    e.zero = d == 8'h00;
    e.cap = 0;
    if (d != 8'h00)
      while (r ? !e.dout[0] : !e.dout[7]) begin
        e.dout = r ? e.dout >> 1 : e.dout << 1;
        e.amt++;
      end
    return e;
  endfunction
  task automatic job(input logic [7:0] d, input logic r, input logic [7:0] ed, input logic [2:0] ea, input logic ez);
    exp_t e;
    int w = 0;
    while (!ready && w < 100) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    din = d;
    dir = r;
    start = 1'b1;
    @(posedge clk);
    e.din = d;
    e.dir = r;
    e.dout = ed;
    e.amt = ea;
    e.zero = ez;
    e.cap = cyc;
    q.push_back(e);
    #2;
    start = 1'b0;
    din = 8'($urandom);
    dir = 1'($urandom);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (reset) low_run = 0;
    else begin
      if (done_tick) begin
        done_cnt++;
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          exp_t e;
          logic [7:0] rt;
          e = q.pop_front();
          chk("dout", dout, e.dout);
          chk("amt", amt, e.amt);
          chk("zero", zero, e.zero);
          chk("latency", cyc - e.cap, e.amt + 2);
          chk("busy_len", low_run, e.amt + 1);
          chk("ready_in_done", ready, 0);
          rt = e.dir ? dout << amt : dout >> amt;
          if (e.din != 8'h00) chk("round_trip", rt, e.din);
        end
      end
      if (ready) low_run = 0;
      else if (!done_tick) low_run++;
    end
  end
  initial begin
    int d0, w;
    exp_t e;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done_tick, 0);
    chk("rst_dout", dout, 0);
    chk("rst_amt", amt, 0);
    chk("rst_zero", zero, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
    job(8'h01, 1'b0, 8'h80, 3'd7, 1'b0);
    job(8'h28, 1'b1, 8'h05, 3'd3, 1'b0);
    job(8'h80, 1'b0, 8'h80, 3'd0, 1'b0);
    job(8'h00, 1'b0, 8'h00, 3'd0, 1'b1);
    job(8'h00, 1'b1, 8'h00, 3'd0, 1'b1);
    job(8'h04, 1'b0, 8'h80, 3'd5, 1'b0);
    @(posedge clk);
    #2;
    din = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    job(8'h10, 1'b1, 8'h01, 3'd4, 1'b0);
    job(8'h01, 1'b0, 8'h80, 3'd7, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_dout", dout, 0);
    chk("abort_amt", amt, 0);
    chk("abort_zero", zero, 0);
    q.delete();
    d0 = done_cnt;
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("no_done_after_abort", done_cnt, d0);
    for (int d = 1; d < 256; d++)
      for (int r = 0; r < 2; r++) begin
        e = model(8'(d), 1'(r));
        job(8'(d), 1'(r), e.dout, e.amt, e.zero);
      end
    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
